// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - MIPS 5-stage hazard/forwarding controller
// Load-use and RAW stalls, registered EX forward selects, redirect flush, multi-cycle EX hold, perf counters.
module pipe_hazard_ctrl #(
  parameter int AW     = 5,
  parameter int MC_LAT = 4,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_redirect,
  input  logic             id_mc,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [AW-1:0]    ex_wn,
  input  logic             mem_regwrite,
  input  logic [AW-1:0]    mem_wn,
  input  logic             wb_regwrite,
  input  logic [AW-1:0]    wb_wn,
  input  logic             mc_done,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             ex_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             rf_byp_rs,
  output logic             rf_byp_rt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {IDLE, MC_BUSY} state_t;

  localparam int MCW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [MCW-1:0] MC_INIT = MCW'((MC_LAT > 1) ? MC_LAT - 1 : 0);

  state_t           state_q, state_d;
  logic [MCW-1:0]   mc_cnt_q, mc_cnt_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic ex_rs_m, ex_rt_m, mem_rs_m, mem_rt_m;
  logic raw_stall, mc_exit;

  assign ex_rs_m  = ex_regwrite  && (ex_wn  == id_rs) && (id_rs != '0) && id_use_rs;
  assign ex_rt_m  = ex_regwrite  && (ex_wn  == id_rt) && (id_rt != '0) && id_use_rt;
  assign mem_rs_m = mem_regwrite && (mem_wn == id_rs) && (id_rs != '0) && id_use_rs;
  assign mem_rt_m = mem_regwrite && (mem_wn == id_rt) && (id_rt != '0) && id_use_rt;

  assign rf_byp_rs = wb_regwrite && (wb_wn == id_rs) && (id_rs != '0);
  assign rf_byp_rt = wb_regwrite && (wb_wn == id_rt) && (id_rt != '0);

  // EX producer is younger than MEM, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m, input logic ex_load);
    logic [1:0] s;
    s = 2'd0;
    if (FWD_EN != 0) begin
      if (ex_m && !ex_load) s = 2'd1;
      else if (mem_m)       s = 2'd2;
    end
    return s;
  endfunction

  always_comb begin
    raw_stall = 1'b0;
    if (FWD_EN != 0) raw_stall = id_valid && ex_memread && (ex_rs_m || ex_rt_m);
    else             raw_stall = id_valid && (ex_rs_m || ex_rt_m || mem_rs_m || mem_rt_m);
  end

  always_comb begin
    state_d     = state_q;
    mc_cnt_d    = mc_cnt_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    mc_exit     = (MC_LAT == 0) ? mc_done : (mc_cnt_q == '0);
    case (state_q)
      MC_BUSY: begin
        ex_hold    = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        mc_cnt_d   = mc_cnt_q - MCW'(1);
        if (mc_exit) state_d = IDLE;
      end
      default: begin
        if (raw_stall) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          fwd_a_d     = 2'd0;
          fwd_b_d     = 2'd0;
        end else begin
          // A redirect seen during a stall is dropped; ID presents it again.
          ifid_flush = id_redirect;
          if (id_valid) begin
            fwd_a_d = fwd_sel(ex_rs_m, mem_rs_m, ex_memread);
            fwd_b_d = fwd_sel(ex_rt_m, mem_rt_m, ex_memread);
            if (id_mc) begin
              state_d  = MC_BUSY;
              mc_cnt_d = MC_INIT;
            end
          end else begin
            fwd_a_d = 2'd0;
            fwd_b_d = 2'd0;
          end
        end
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mc_cnt_q    <= '0;
      fwd_a_q     <= 2'd0;
      fwd_b_q     <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - bench for pipe_hazard_ctrl
// u0: MC_LAT=4 FWD_EN=1 CNT_W=16; u1: MC_LAT=0 FWD_EN=0 CNT_W=2; shared stimulus.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rs, id_use_rt, id_redirect, id_mc;
  logic [4:0] id_rs, id_rt, ex_wn, mem_wn, wb_wn;
  logic ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, mc_done;

  logic pcw0, ifw0, fl0, bub0, hold0, brs0, brt0;
  logic [1:0] fa0, fb0;
  logic [15:0] sc0, fc0;
  logic pcw1, ifw1, fl1, bub1, hold1, brs1, brt1;
  logic [1:0] fa1, fb1;
  logic [1:0] sc1, fc1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.AW(5), .MC_LAT(4), .FWD_EN(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_redirect(id_redirect), .id_mc(id_mc),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_wn(ex_wn),
    .mem_regwrite(mem_regwrite), .mem_wn(mem_wn), .wb_regwrite(wb_regwrite), .wb_wn(wb_wn),
    .mc_done(mc_done), .pc_write(pcw0), .ifid_write(ifw0), .ifid_flush(fl0),
    .idex_bubble(bub0), .ex_hold(hold0), .fwd_a(fa0), .fwd_b(fb0),
    .rf_byp_rs(brs0), .rf_byp_rt(brt0), .stall_cnt(sc0), .flush_cnt(fc0));

  pipe_hazard_ctrl #(.AW(5), .MC_LAT(0), .FWD_EN(0), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_redirect(id_redirect), .id_mc(id_mc),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_wn(ex_wn),
    .mem_regwrite(mem_regwrite), .mem_wn(mem_wn), .wb_regwrite(wb_regwrite), .wb_wn(wb_wn),
    .mc_done(mc_done), .pc_write(pcw1), .ifid_write(ifw1), .ifid_flush(fl1),
    .idex_bubble(bub1), .ex_hold(hold1), .fwd_a(fa1), .fwd_b(fb1),
    .rf_byp_rs(brs1), .rf_byp_rt(brt1), .stall_cnt(sc1), .flush_cnt(fc1));

  typedef struct {
    logic v; logic [4:0] rs; logic [4:0] rt; logic urs; logic urt; logic redir;
    logic exrw; logic exmr; logic [4:0] exwn; logic memrw; logic [4:0] memwn;
    logic wbrw; logic [4:0] wbwn;
    logic e_pcw; logic e_bub; logic e_fl; logic e_brs; logic e_brt;
    logic [1:0] e_fa; logic [1:0] e_fb; logic e_pcw1;
  } vec_t;

  vec_t vecs[13];

  // Reference model state, one slot per instance.
  int lat[2]  = '{4, 0};
  int fen[2]  = '{1, 0};
  int cmax[2] = '{65535, 3};
  int m_left[2], m_fa[2], m_fb[2], m_sc[2], m_fc[2];
  bit m_wait[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_redirect = 0; id_mc = 0; ex_regwrite = 0; ex_memread = 0; ex_wn = 0;
    mem_regwrite = 0; mem_wn = 0; wb_regwrite = 0; wb_wn = 0; mc_done = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic apply_vec(input vec_t t);
    id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_use_rs = t.urs; id_use_rt = t.urt;
    id_redirect = t.redir; id_mc = 0; ex_regwrite = t.exrw; ex_memread = t.exmr; ex_wn = t.exwn;
    mem_regwrite = t.memrw; mem_wn = t.memwn; wb_regwrite = t.wbrw; wb_wn = t.wbwn; mc_done = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0; m_wait[i] = 0; m_fa[i] = 0; m_fb[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  function automatic int fsel(input bit ex_m, input bit mem_m, input bit fwd_on);
    if (!fwd_on) return 0;
    if (ex_m && !ex_memread) return 1;
    if (mem_m) return 2;
    return 0;
  endfunction

  task automatic model_step(input int i);
    bit busy, ers, ert, mrs, mrt, haz, e_pcw, e_fl, brs, brt;
    logic [10:0] act, exp;
    busy = (lat[i] > 0) ? (m_left[i] > 0) : m_wait[i];
    ers = ex_regwrite && ex_wn == id_rs && id_rs != 0 && id_use_rs;
    ert = ex_regwrite && ex_wn == id_rt && id_rt != 0 && id_use_rt;
    mrs = mem_regwrite && mem_wn == id_rs && id_rs != 0 && id_use_rs;
    mrt = mem_regwrite && mem_wn == id_rt && id_rt != 0 && id_use_rt;
    brs = wb_regwrite && wb_wn == id_rs && id_rs != 0;
    brt = wb_regwrite && wb_wn == id_rt && id_rt != 0;
    if (fen[i] != 0) haz = id_valid && ex_memread && (ers || ert);
    else             haz = id_valid && (ers || ert || mrs || mrt);
    e_pcw = !busy && !haz;
    e_fl  = !busy && !haz && id_redirect;
    exp = {e_pcw, e_pcw, e_fl, !busy && haz, busy, 2'(m_fa[i]), 2'(m_fb[i]), brs, brt};
    if (i == 0) act = {pcw0, ifw0, fl0, bub0, hold0, fa0, fb0, brs0, brt0};
    else        act = {pcw1, ifw1, fl1, bub1, hold1, fa1, fb1, brs1, brt1};
    chk(i == 0 ? "rand_ctl_u0" : "rand_ctl_u1", 32'(act), 32'(exp));
    chk(i == 0 ? "rand_stall_u0" : "rand_stall_u1", i == 0 ? 32'(sc0) : 32'(sc1), m_sc[i]);
    chk(i == 0 ? "rand_flush_u0" : "rand_flush_u1", i == 0 ? 32'(fc0) : 32'(fc1), m_fc[i]);
    if (rst) begin
      m_left[i] = 0; m_wait[i] = 0; m_fa[i] = 0; m_fb[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end else begin
      if (!e_pcw && m_sc[i] < cmax[i]) m_sc[i]++;
      if (e_fl && m_fc[i] < cmax[i]) m_fc[i]++;
      if (busy) begin
        if (lat[i] > 0) m_left[i]--;
        else if (mc_done) m_wait[i] = 0;
      end else if (!haz && id_valid) begin
        m_fa[i] = fsel(ers, mrs, fen[i] != 0);
        m_fb[i] = fsel(ert, mrt, fen[i] != 0);
        if (id_mc) begin
          if (lat[i] > 0) m_left[i] = lat[i];
          else m_wait[i] = 1;
        end
      end else begin
        m_fa[i] = 0; m_fb[i] = 0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //            v rs rt urs urt rd exrw exmr exwn mrw mwn wrw wwn pcw bub fl brs brt fa fb pcw1
    vecs[0]  = '{1, 2, 4, 1, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 5, 0, 1, 0, 0, 1, 0, 5, 1, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 5, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0};
    vecs[3]  = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[4]  = '{1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1};
    vecs[5]  = '{1, 3, 0, 1, 0, 1, 1, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 7, 7, 1, 1, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 1, 1, 0, 0, 1};
    vecs[7]  = '{1, 1, 3, 1, 1, 0, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    vecs[8]  = '{1, 4, 0, 0, 0, 0, 1, 1, 4, 1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[9]  = '{0, 2, 2, 1, 1, 0, 1, 1, 2, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[10] = '{1, 6, 6, 1, 1, 0, 0, 1, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[11] = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[12] = '{1, 6, 5, 1, 1, 0, 1, 0, 5, 1, 6, 0, 0, 1, 0, 0, 0, 0, 2, 1, 0};

    rst = 1;
    idle_in();
    step();
    step();
    rst = 0;
    @(negedge clk);
    chk("reset_ctl", {pcw0, ifw0, fl0, bub0, hold0, fa0, fb0}, 9'b110000000);
    chk("reset_cnt", {sc0, fc0}, 0);

    foreach (vecs[k]) begin
      do_reset();
      apply_vec(vecs[k]);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", k), {pcw0, ifw0, bub0, fl0, brs0, brt0, hold0},
          {vecs[k].e_pcw, vecs[k].e_pcw, vecs[k].e_bub, vecs[k].e_fl, vecs[k].e_brs, vecs[k].e_brt, 1'b0});
      chk($sformatf("vec%0d_pcw_u1", k), pcw1, vecs[k].e_pcw1);
      step();
      idle_in();
      @(negedge clk);
      chk($sformatf("vec%0d_fwd", k), {fa0, fb0}, {vecs[k].e_fa, vecs[k].e_fb});
    end

    // Load-use: one stall, then MEM/WB forward once the load reaches MEM.
    do_reset();
    id_valid = 1; id_rs = 2; id_use_rs = 1; ex_regwrite = 1; ex_memread = 1; ex_wn = 2;
    @(negedge clk);
    chk("lu_stall", {pcw0, bub0}, 2'b01);
    step();
    ex_regwrite = 0; ex_memread = 0; ex_wn = 0; mem_regwrite = 1; mem_wn = 2;
    @(negedge clk);
    chk("lu_advance", pcw0, 1);
    chk("lu_stall_cnt", sc0, 1);
    step();
    idle_in();
    @(negedge clk);
    chk("lu_fwd_a", fa0, 2);

    // Multi-cycle: fixed latency on u0, handshake on u1 (whose 2-bit counter saturates).
    do_reset();
    id_valid = 1; id_mc = 1;
    @(negedge clk);
    chk("mc_issue", {pcw0, hold0, pcw1, hold1}, 4'b1010);
    step();
    idle_in();
    n = 0;
    @(negedge clk);
    while (hold0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("mc_hold_cycles", n, 4);
    chk("mc_stall_cnt", sc0, 4);
    chk("mc0_released", pcw0, 1);
    chk("mc1_waiting", {hold1, pcw1}, 2'b10);
    chk("mc1_cnt_sat", sc1, 3);
    mc_done = 1;
    step();
    mc_done = 0;
    @(negedge clk);
    chk("mc1_released", {hold1, pcw1}, 2'b01);

    // Reset in the middle of a multi-cycle hold.
    do_reset();
    id_valid = 1; id_mc = 1; id_rs = 5; id_use_rs = 1; ex_regwrite = 1; ex_wn = 5;
    @(negedge clk);
    chk("rmc_issue", pcw0, 1);
    step();
    idle_in();
    @(negedge clk);
    chk("rmc_busy", {hold0, fa0}, 3'b101);
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("rmc_after_rst", {hold0, pcw0, fa0, fb0}, 6'b010000);
    chk("rmc_cnt", {sc0, fc0, sc1, fc1}, 0);

    // No-forwarding instance stalls until the producer is in WB.
    do_reset();
    id_valid = 1; id_rs = 6; id_use_rs = 1; ex_regwrite = 1; ex_wn = 6;
    @(negedge clk);
    chk("nf_ex_stall", {pcw1, bub1, pcw0}, 3'b011);
    step();
    ex_regwrite = 0; ex_wn = 0; mem_regwrite = 1; mem_wn = 6;
    @(negedge clk);
    chk("nf_mem_stall", pcw1, 0);
    step();
    mem_regwrite = 0; mem_wn = 0; wb_regwrite = 1; wb_wn = 6;
    @(negedge clk);
    chk("nf_wb_go", {pcw1, brs1}, 2'b11);

    // Redirect blocked by load-use, then taken once the stall clears.
    do_reset();
    id_valid = 1; id_rs = 3; id_use_rs = 1; id_redirect = 1;
    ex_regwrite = 1; ex_memread = 1; ex_wn = 3;
    @(negedge clk);
    chk("rd_blocked", {fl0, pcw0}, 2'b00);
    step();
    ex_regwrite = 0; ex_memread = 0; ex_wn = 0; mem_regwrite = 1; mem_wn = 3;
    @(negedge clk);
    chk("rd_flush", {fl0, pcw0}, 2'b11);
    step();
    idle_in();
    @(negedge clk);
    chk("rd_flush_cnt", {fl0, fc0}, 17'd1);

    // Randomised run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_use_rs    = $urandom_range(0, 1) == 1;
      id_use_rt    = $urandom_range(0, 1) == 1;
      id_redirect  = ($urandom_range(0, 3) == 0);
      id_mc        = ($urandom_range(0, 9) == 0);
      ex_regwrite  = $urandom_range(0, 1) == 1;
      ex_memread   = $urandom_range(0, 1) == 1;
      ex_wn        = 5'($urandom_range(0, 3));
      mem_regwrite = $urandom_range(0, 1) == 1;
      mem_wn       = 5'($urandom_range(0, 3));
      wb_regwrite  = $urandom_range(0, 1) == 1;
      wb_wn        = 5'($urandom_range(0, 3));
      mc_done      = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      model_step(0);
      model_step(1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
